// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung accumulator sequencer and its adder harness.
package bk_pkg;

  localparam int unsigned BK_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } bk_state_e;

  // Operand bus ordering: even bits carry the accumulator, odd bits the sample.
  function automatic logic [2*BK_WIDTH-1:0] interleave(input logic [BK_WIDTH-1:0] a,
                                                       input logic [BK_WIDTH-1:0] b);
    logic [2*BK_WIDTH-1:0] bus;
    bus = '0;
    for (int i = 0; i < int'(BK_WIDTH); i++) begin
      bus[2*i]   = a[i];
      bus[2*i+1] = b[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/bk_accum_ctrl_if.sv
// Sample stream, adder operand/sum bus and frame result stream.
interface bk_accum_ctrl_if #(
  parameter int unsigned WIDTH = bk_pkg::BK_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [2*WIDTH-1:0] add_ops;
  logic [WIDTH:0]     add_sum;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_acc;
  logic               out_ovf;
  logic [7:0]         out_count;

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, add_sum, out_ready,
    output in_ready, add_ops, out_valid, out_acc, out_ovf, out_count
  );

  // Environment side: sample source, adder and result consumer.
  modport master (
    output in_valid, in_data, add_sum, out_ready,
    input  in_ready, add_ops, out_valid, out_acc, out_ovf, out_count
  );

endinterface

// File: rtl/bk_operand_pack.sv
// Places accumulator and sample registers onto the interleaved adder operand bus.
module bk_operand_pack
  import bk_pkg::*;
(
  input  logic [BK_WIDTH-1:0]   acc,
  input  logic [BK_WIDTH-1:0]   op,
  output logic [2*BK_WIDTH-1:0] ops
);

  // Pure wiring; bit ordering lives in the shared function.
  assign ops = interleave(acc, op);

endmodule

// File: rtl/bk_accum_ctrl.sv
// Frame accumulator that feeds and consumes an external combinational adder.
module bk_accum_ctrl
  import bk_pkg::*;
#(
  parameter int unsigned WIDTH = BK_WIDTH,
  parameter int unsigned FRAME = 16,
  parameter bit          SAT   = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  bk_accum_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 8;

  bk_state_e        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // State and datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
    end
  end

  // Next-state and datapath update; clear overrides every state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      op_d    = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_d    = bus.in_data;
            state_d = EVAL;
          end
        end
        EVAL: begin
          acc_d   = (SAT && bus.add_sum[WIDTH]) ? '1 : bus.add_sum[WIDTH-1:0];
          ovf_d   = ovf_q | bus.add_sum[WIDTH];
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CNT_W'(FRAME)) ? HOLD : IDLE;
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  bk_operand_pack u_pack (
    .acc (acc_q),
    .op  (op_q),
    .ops (bus.add_ops)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_bk_accum_ctrl.sv
// Bench: four sequencer configurations driven in parallel, each with its own behavioural adder.
module tb_bk_accum_ctrl;

  localparam int unsigned W = 12;
  localparam int NDUT = 4;

  function automatic int fr_of(input int k);
    case (k)
      0: return 4;
      1: return 2;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit sat_of(input int k);
    return (k == 1 || k == 3);
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic [W-1:0] in_data;
  logic out_ready;

  logic           ir_w  [NDUT];
  logic           ov_w  [NDUT];
  logic [W-1:0]   acc_w [NDUT];
  logic           ovf_w [NDUT];
  logic [7:0]     cnt_w [NDUT];
  logic [2*W-1:0] ops_w [NDUT];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bk_accum_ctrl_if #(.WIDTH(W)) u_if ();
    logic [W-1:0] a_op, b_op;

    assign u_if.in_valid  = in_valid;
    assign u_if.in_data   = in_data;
    assign u_if.out_ready = out_ready;

    // Behavioural adder: split the interleaved bus and add.
    always_comb begin
      a_op = '0;
      b_op = '0;
      for (int i = 0; i < int'(W); i++) begin
        a_op[i] = u_if.add_ops[2*i];
        b_op[i] = u_if.add_ops[2*i+1];
      end
    end
    assign u_if.add_sum = {1'b0, a_op} + {1'b0, b_op};

    bk_accum_ctrl #(.WIDTH(W), .FRAME(fr_of(g)), .SAT(sat_of(g))) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (u_if)
    );

    assign ir_w[g]  = u_if.in_ready;
    assign ov_w[g]  = u_if.out_valid;
    assign acc_w[g] = u_if.out_acc;
    assign ovf_w[g] = u_if.out_ovf;
    assign cnt_w[g] = u_if.out_count;
    assign ops_w[g] = u_if.add_ops;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] pack_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) begin
      r = r | ((2*W)'(a[i]) << (2*i)) | ((2*W)'(b[i]) << (2*i + 1));
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    step();
  endtask

  // Transaction-level scoreboard used during the random phase.
  bit           mon_en = 1'b0;
  int           m_acc [NDUT];
  bit           m_ovf [NDUT];
  int           m_n   [NDUT];
  logic [W:0]   expq  [NDUT][$];
  int           seen  [NDUT];

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NDUT; k++) begin
        if (!rst_n || clear) begin
          m_acc[k] = 0; m_ovf[k] = 1'b0; m_n[k] = 0;
          expq[k].delete();
        end else begin
          if (ov_w[k] && out_ready) begin
            if (expq[k].size() == 0) begin
              chk($sformatf("rnd_unexpected_result[%0d]", k), 32'(ov_w[k]), 32'd0);
            end else begin
              logic [W:0] e;
              e = expq[k].pop_front();
              chk($sformatf("rnd_acc[%0d]", k), 32'(acc_w[k]), 32'(e[W-1:0]));
              chk($sformatf("rnd_ovf[%0d]", k), 32'(ovf_w[k]), 32'(e[W]));
              chk($sformatf("rnd_cnt[%0d]", k), 32'(cnt_w[k]), 32'(fr_of(k)));
              seen[k]++;
            end
          end
          if (in_valid && ir_w[k]) begin
            int s;
            s = m_acc[k] + int'(in_data);
            if (s > 4095) begin
              m_ovf[k] = 1'b1;
              m_acc[k] = sat_of(k) ? 4095 : s - 4096;
            end else begin
              m_acc[k] = s;
            end
            m_n[k]++;
            if (m_n[k] == fr_of(k)) begin
              expq[k].push_back({m_ovf[k], W'(m_acc[k])});
              m_acc[k] = 0; m_ovf[k] = 1'b0; m_n[k] = 0;
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic         clr;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_acc;
    logic [W-1:0] e_op;
    logic [7:0]   e_cnt;
    logic         e_ovf;
  } vec_t;

  vec_t vt [16];

  initial begin
    // Per-cycle vectors for the FRAME=4, wrapping instance.
    vt[0]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 8'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0, 12'h000, 12'h001, 8'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h001, 12'h001, 8'd1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 12'h002, 1'b1, 1'b0, 1'b0, 12'h001, 12'h002, 8'd1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h003, 12'h002, 8'd2, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 12'h003, 1'b1, 1'b0, 1'b0, 12'h003, 12'h003, 8'd2, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h006, 12'h003, 8'd3, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 12'h004, 1'b1, 1'b0, 1'b0, 12'h006, 12'h004, 8'd3, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h00A, 12'h004, 8'd4, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 12'h004, 8'd0, 1'b0};
    vt[10] = '{1'b1, 1'b1, 12'h007, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 8'd0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0, 12'h000, 12'hFFF, 8'd0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'hFFF, 12'hFFF, 8'd1, 1'b0};
    vt[13] = '{1'b0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h001, 8'd1, 1'b0};
    vt[14] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 12'h001, 8'd2, 1'b1};
    vt[15] = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 8'd0, 1'b0};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      m_acc[k] = 0; m_ovf[k] = 1'b0; m_n[k] = 0; seen[k] = 0;
    end
    step();
    step();

    // Reset state of every instance.
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k), 32'(ir_w[k]), 32'd1);
      chk($sformatf("rst_out_valid[%0d]", k), 32'(ov_w[k]), 32'd0);
      chk($sformatf("rst_acc[%0d]", k), 32'(acc_w[k]), 32'd0);
      chk($sformatf("rst_cnt[%0d]", k), 32'(cnt_w[k]), 32'd0);
      chk($sformatf("rst_ovf[%0d]", k), 32'(ovf_w[k]), 32'd0);
      chk($sformatf("rst_ops[%0d]", k), 32'(ops_w[k]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Table-driven cycle vectors.
    for (int i = 0; i < 16; i++) begin
      clear = vt[i].clr; in_valid = vt[i].iv; in_data = vt[i].d; out_ready = vt[i].ordy;
      step();
      chk($sformatf("tbl%0d_in_ready", i), 32'(ir_w[0]), 32'(vt[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov_w[0]), 32'(vt[i].e_ov));
      chk($sformatf("tbl%0d_count", i), 32'(cnt_w[0]), 32'(vt[i].e_cnt));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf_w[0]), 32'(vt[i].e_ovf));
      chk($sformatf("tbl%0d_add_ops", i), 32'(ops_w[0]), 32'(pack_ref(vt[i].e_acc, vt[i].e_op)));
      if (vt[i].e_ov) chk($sformatf("tbl%0d_out_acc", i), 32'(acc_w[0]), 32'(vt[i].e_acc));
    end
    clear = 1'b0; in_valid = 1'b0;

    // Saturate vs wrap, FRAME=2.
    out_ready = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    send(12'hFFF);
    send(12'h002);
    chk("sat_valid", 32'(ov_w[1]), 32'd1);
    chk("sat_acc", 32'(acc_w[1]), 32'hFFF);
    chk("sat_ovf", 32'(ovf_w[1]), 32'd1);
    chk("sat_cnt", 32'(cnt_w[1]), 32'd2);
    chk("wrap_valid", 32'(ov_w[2]), 32'd1);
    chk("wrap_acc", 32'(acc_w[2]), 32'h001);
    chk("wrap_ovf", 32'(ovf_w[2]), 32'd1);

    // Backpressure, FRAME=1.
    clear = 1'b1; step(); clear = 1'b0;
    send(12'h123);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), 32'(ov_w[3]), 32'd1);
      chk($sformatf("bp%0d_acc", c), 32'(acc_w[3]), 32'h123);
      chk($sformatf("bp%0d_cnt", c), 32'(cnt_w[3]), 32'd1);
      chk($sformatf("bp%0d_in_ready", c), 32'(ir_w[3]), 32'd0);
      step();
    end
    out_ready = 1'b1; step();
    chk("bp_release_in_ready", 32'(ir_w[3]), 32'd1);
    chk("bp_release_valid", 32'(ov_w[3]), 32'd0);

    // Clear during EVAL of the third sample.
    clear = 1'b1; step(); clear = 1'b0;
    send(12'h005);
    send(12'h005);
    in_valid = 1'b1; in_data = 12'h005; step();
    in_valid = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    chk("clr_eval_valid", 32'(ov_w[0]), 32'd0);
    chk("clr_eval_cnt", 32'(cnt_w[0]), 32'd0);
    chk("clr_eval_acc", 32'(acc_w[0]), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(12'h010);
    chk("post_clr_valid", 32'(ov_w[0]), 32'd1);
    chk("post_clr_acc", 32'(acc_w[0]), 32'h040);
    chk("post_clr_ovf", 32'(ovf_w[0]), 32'd0);
    chk("post_clr_cnt", 32'(cnt_w[0]), 32'd4);

    // Clear together with out_ready in HOLD drops the result.
    out_ready = 1'b1; clear = 1'b1; step(); clear = 1'b0;
    chk("clr_hold_valid", 32'(ov_w[0]), 32'd0);
    chk("clr_hold_acc", 32'(acc_w[0]), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(12'h003);
    chk("next_frame_acc", 32'(acc_w[0]), 32'h00C);
    out_ready = 1'b1; step();

    // Reset mid-frame.
    send(12'h001);
    send(12'h002);
    rst_n = 1'b0; step();
    chk("midrst_in_ready", 32'(ir_w[0]), 32'd1);
    chk("midrst_valid", 32'(ov_w[0]), 32'd0);
    chk("midrst_cnt", 32'(cnt_w[0]), 32'd0);
    chk("midrst_acc", 32'(acc_w[0]), 32'd0);
    chk("midrst_ops", 32'(ops_w[0]), 32'd0);
    rst_n = 1'b1; step();

    // Random traffic against the scoreboard.
    mon_en = 1'b1;
    clear = 1'b1; step(); clear = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(9) < 7);
      in_data   = ($urandom_range(3) == 0) ? W'(12'hFFF - $urandom_range(7)) : W'($urandom);
      out_ready = ($urandom_range(9) < 6);
      clear     = ($urandom_range(99) < 2);
      step();
    end
    clear = 1'b0; in_valid = 1'b0;
    step();
    mon_en = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rnd_results_seen[%0d]", k), 32'(seen[k] > 0), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bk_accum_ctrl.md
Name: bk_accum_ctrl

Overview:
- Sequencer wrapped around the 12-bit combinational Brent-Kung adder; acts as both its upstream feeder and its downstream consumer.
- Accepts a stream of 12-bit samples over valid/ready and drives the adder's 24-bit interleaved operand bus from registers.
- Captures the adder's 13-bit sum into a running accumulator and emits one accumulated result per frame of FRAME samples.
- Keeps the reg -> adder -> reg path to exactly one cycle.

Parameters:
- WIDTH, 12, operand/accumulator width; must match the adder (operand bus 2*WIDTH, sum WIDTH+1).
- FRAME, 16, samples accumulated per output result; legal range 1..255.
- SAT, 1, 1 = accumulator saturates to all-ones on carry-out; 0 = wraps modulo 2^WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous abort/flush of the current frame.
- in_valid  in  1  sample available.
- in_ready  out  1  block can take a sample this cycle.
- in_data  in  WIDTH  sample.
- add_ops  out  2*WIDTH  adder operand bus, interleaved: add_ops[2i]=acc_r[i], add_ops[2i+1]=op_r[i].
- add_sum  in  WIDTH+1  adder result; bit WIDTH is carry-out.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer accepts result.
- out_acc  out  WIDTH  accumulated frame value.
- out_ovf  out  1  sticky: at least one carry-out occurred in this frame.
- out_count  out  8  samples accumulated in this frame (equals FRAME when out_valid=1).

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; acc_r, op_r, count, ovf all 0; in_ready=1 once out of reset; out_valid=0; add_ops=0.
- FSM states IDLE, EVAL, HOLD; outputs decode from registered state only, with no combinational in->out path.
- IDLE: in_ready=1. On in_valid=1, op_r<=in_data and state goes to EVAL.
- EVAL (exactly 1 cycle): in_ready=0; add_ops is driven from op_r and acc_r. At the end of the cycle:
  - acc_r <= (SAT && add_sum[WIDTH]) ? all-ones : add_sum[WIDTH-1:0].
  - ovf <= ovf | add_sum[WIDTH].
  - count <= count+1.
  - Next state is HOLD if count+1==FRAME, else IDLE.
- HOLD: out_valid=1; out_acc=acc_r, out_ovf=ovf, out_count=count, all held stable while out_valid=1 and out_ready=0. On out_ready=1, acc_r, count and ovf are zeroed and state goes to IDLE. No sample is accepted in HOLD (in_ready=0).
- Throughput: 1 sample per 2 cycles. Latency from the last sample handshake to out_valid is 2 cycles.
- add_ops is always a pure function of registers. op_r retains its last value outside EVAL, and add_sum is ignored outside EVAL.
- clear=1 is honoured in any state: next cycle state=IDLE and acc_r, count, ovf = 0 (op_r is also cleared).
  - clear beats in_valid (the sample is not accepted, even though in_ready=1 that cycle; the upstream source must treat the handshake as void whenever clear=1).
  - clear beats out_ready (the result is dropped).
  - clear during EVAL discards the add.
- rst_n has priority over clear.
- FRAME=1: every sample produces a result, giving IDLE -> EVAL -> HOLD.
- Wrap (SAT=0): 0xFFF+0x001 gives acc=0x000, ovf=1. Saturate (SAT=1): the same add gives acc=0xFFF, ovf=1, and acc stays at 0xFFF on later carries.

Decomposition:
- Shared package bk_pkg holds:
  - BK_WIDTH=12.
  - The state enum typedef {IDLE, EVAL, HOLD}.
  - Function interleave(a,b) returning the 2*WIDTH bus. The adder harness reuses the same function.
- One sub-module, bk_operand_pack (pure interleave of acc_r/op_r onto add_ops), so the bus bit ordering is defined in one place.
- The adder itself is instantiated outside this block; the testbench instantiates both.

Test Plan:
- Reset then FRAME=4, samples 0x001,0x002,0x003,0x004 with out_ready=1 -> one out_valid pulse with out_acc=0x00A, out_ovf=0, out_count=4; in_ready toggles 1,0 per sample.
- SAT=1, FRAME=2, samples 0xFFF,0x002 -> out_acc=0xFFF, out_ovf=1. With SAT=0 the same samples -> out_acc=0x001, out_ovf=1.
- Backpressure: FRAME=1, sample 0x123, out_ready=0 for 5 cycles -> out_valid, out_acc=0x123 and out_count=1 held stable for 5 cycles; in_ready=0 throughout; after out_ready=1, in_ready=1 next cycle.
- clear asserted in EVAL of the 3rd of 4 samples -> no out_valid; the next 4 samples 0x010 each yield out_acc=0x040, out_ovf=0.
- clear and in_valid in the same IDLE cycle -> sample not taken, count stays 0; clear together with out_ready in HOLD -> result dropped, acc reads 0 in the next frame.
- rst_n=0 mid-frame (after 2 samples) -> all outputs return to reset values next cycle; add_ops=0.
